// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with branch redirect, halt, stall and run-cycle counter
module fetch_unit #(
  parameter int A     = 10,
  parameter int W     = 9,
  parameter int START = 0
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic [7:0]   Offset,
  input  logic [A-1:0] Target,
  input  logic         Halt,
  input  logic [W-1:0] InstIn,
  output logic [A-1:0] InstAddress,
  output logic [W-1:0] Instr,
  output logic [A-1:0] InstrAddr,
  output logic         IValid,
  output logic         Done,
  output logic [15:0]  CycleCnt
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state;
  logic [A-1:0] br_target;
  // Branch destination: relative to the address of the instruction in IR, wrapping mod 2^A
  always_comb br_target = BranchRel ? InstrAddr + A'($signed(Offset)) : Target;
  // Control FSM with registered fetch, flush, halt and saturating cycle count
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state       <= IDLE;
      InstAddress <= A'(START);
      Instr       <= '0;
      InstrAddr   <= '0;
      IValid      <= 1'b0;
      Done        <= 1'b0;
      CycleCnt    <= '0;
    end else if (Start) begin
      state       <= RUN;
      InstAddress <= A'(START);
      CycleCnt    <= '0;
      IValid      <= 1'b0;
      Done        <= 1'b0;
    end else if (state == RUN) begin
      CycleCnt <= CycleCnt + 16'(CycleCnt != 16'hFFFF);
      if (!Stall) begin
        if (IValid && Halt) begin
          state  <= HALTED;
          Done   <= 1'b1;
          IValid <= 1'b0;
        end else if (IValid && BranchEn) begin
          InstAddress <= br_target;
          IValid      <= 1'b0;
        end else begin
          Instr       <= InstIn;
          InstrAddr   <= InstAddress;
          IValid      <= 1'b1;
          InstAddress <= InstAddress + A'(1);
        end
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus reset and saturation sequences for fetch_unit
module tb_fetch_unit;
  logic        Clk = 1'b0, Reset_n = 1'b1, Start = 1'b0, Stall = 1'b0;
  logic        BranchEn = 1'b0, BranchRel = 1'b0, Halt = 1'b0;
  logic [7:0]  Offset = '0;
  logic [9:0]  Target = '0;
  logic [8:0]  InstIn;
  logic [9:0]  InstAddress, InstrAddr;
  logic [8:0]  Instr;
  logic        IValid, Done;
  logic [15:0] CycleCnt;
  int checks = 0, fails = 0;

  fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .BranchEn(BranchEn), .BranchRel(BranchRel), .Offset(Offset), .Target(Target),
    .Halt(Halt), .InstIn(InstIn), .InstAddress(InstAddress), .Instr(Instr),
    .InstrAddr(InstrAddr), .IValid(IValid), .Done(Done), .CycleCnt(CycleCnt)
  );

  function automatic logic [8:0] rom(input logic [9:0] a);
    return 9'((int'(a) * 7 + 1) ^ 9'h0A5);
  endfunction
  assign InstIn = rom(InstAddress);

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  typedef struct {
    bit start, stall, br, rel;
    logic [7:0] off;
    logic [9:0] tgt;
    bit halt;
    logic [9:0] pc;
    bit iv;
    logic [9:0] ia;
    bit done;
    int cnt;
  } vec_t;
  vec_t v[28];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{1,0,0,0,8'h00,10'h000,0, 10'h000,0,10'h000,0, 0};
    v[1]  = '{0,0,0,0,8'h00,10'h000,0, 10'h001,1,10'h000,0, 1};
    v[2]  = '{0,0,0,0,8'h00,10'h000,0, 10'h002,1,10'h001,0, 2};
    v[3]  = '{0,0,0,0,8'h00,10'h000,0, 10'h003,1,10'h002,0, 3};
    v[4]  = '{0,0,0,0,8'h00,10'h000,0, 10'h004,1,10'h003,0, 4};
    v[5]  = '{0,0,0,0,8'h00,10'h000,0, 10'h005,1,10'h004,0, 5};
    v[6]  = '{0,1,0,0,8'h00,10'h000,0, 10'h005,1,10'h004,0, 6};
    v[7]  = '{0,1,1,0,8'h00,10'h100,1, 10'h005,1,10'h004,0, 7};
    v[8]  = '{0,1,0,0,8'h00,10'h000,0, 10'h005,1,10'h004,0, 8};
    v[9]  = '{0,0,1,0,8'h00,10'h010,0, 10'h010,0,10'h000,0, 9};
    v[10] = '{0,0,0,0,8'h00,10'h000,1, 10'h011,1,10'h010,0, 10};
    v[11] = '{0,0,1,1,8'hFD,10'h000,0, 10'h00D,0,10'h000,0, 11};
    v[12] = '{0,0,0,0,8'h00,10'h000,0, 10'h00E,1,10'h00D,0, 12};
    v[13] = '{0,0,1,0,8'h00,10'h200,0, 10'h200,0,10'h000,0, 13};
    v[14] = '{0,0,0,0,8'h00,10'h000,0, 10'h201,1,10'h200,0, 14};
    v[15] = '{0,0,1,0,8'h00,10'h3FF,0, 10'h3FF,0,10'h000,0, 15};
    v[16] = '{0,0,0,0,8'h00,10'h000,0, 10'h000,1,10'h3FF,0, 16};
    v[17] = '{0,0,0,0,8'h00,10'h000,0, 10'h001,1,10'h000,0, 17};
    v[18] = '{0,0,0,0,8'h00,10'h000,0, 10'h002,1,10'h001,0, 18};
    v[19] = '{0,0,1,1,8'hFC,10'h000,0, 10'h3FD,0,10'h000,0, 19};
    v[20] = '{0,0,0,0,8'h00,10'h000,0, 10'h3FE,1,10'h3FD,0, 20};
    v[21] = '{0,0,1,0,8'h00,10'h100,1, 10'h3FE,0,10'h000,1, 21};
    v[22] = '{0,0,0,0,8'h00,10'h000,0, 10'h3FE,0,10'h000,1, 21};
    v[23] = '{1,0,0,0,8'h00,10'h000,0, 10'h000,0,10'h000,0, 0};
    v[24] = '{0,0,0,0,8'h00,10'h000,0, 10'h001,1,10'h000,0, 1};
    v[25] = '{1,1,1,0,8'h00,10'h100,1, 10'h000,0,10'h000,0, 0};
    v[26] = '{0,1,0,0,8'h00,10'h000,0, 10'h000,0,10'h000,0, 1};
    v[27] = '{0,0,0,0,8'h00,10'h000,0, 10'h001,1,10'h000,0, 2};

    #1 Reset_n = 1'b0;
    #2;
    chk("reset pc", int'(InstAddress), 0);
    chk("reset instr", int'(Instr), 0);
    chk("reset iaddr", int'(InstrAddr), 0);
    chk("reset ivalid", int'(IValid), 0);
    chk("reset done", int'(Done), 0);
    chk("reset cnt", int'(CycleCnt), 0);
    @(negedge Clk) Reset_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      Start = v[i].start; Stall = v[i].stall; BranchEn = v[i].br; BranchRel = v[i].rel;
      Offset = v[i].off; Target = v[i].tgt; Halt = v[i].halt;
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("v%0d pc", i), int'(InstAddress), int'(v[i].pc));
      chk($sformatf("v%0d ivalid", i), int'(IValid), int'(v[i].iv));
      chk($sformatf("v%0d done", i), int'(Done), int'(v[i].done));
      chk($sformatf("v%0d cnt", i), int'(CycleCnt), v[i].cnt);
      if (v[i].iv) begin
        chk($sformatf("v%0d iaddr", i), int'(InstrAddr), int'(v[i].ia));
        chk($sformatf("v%0d instr", i), int'(Instr), int'(rom(v[i].ia)));
      end
    end
    Start = 0; Stall = 0; BranchEn = 0; BranchRel = 0; Halt = 0;

    #2 Reset_n = 1'b0;
    #1;
    chk("async pc", int'(InstAddress), 0);
    chk("async instr", int'(Instr), 0);
    chk("async iaddr", int'(InstrAddr), 0);
    chk("async ivalid", int'(IValid), 0);
    chk("async done", int'(Done), 0);
    chk("async cnt", int'(CycleCnt), 0);
    #1 Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("idle%0d pc", i), int'(InstAddress), 0);
      chk($sformatf("idle%0d ivalid", i), int'(IValid), 0);
      chk($sformatf("idle%0d cnt", i), int'(CycleCnt), 0);
    end

    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk) Start = 1'b0;
    repeat (65534) @(posedge Clk);
    @(negedge Clk);
    chk("cnt 65534", int'(CycleCnt), 65534);
    @(posedge Clk);
    @(negedge Clk);
    chk("cnt max", int'(CycleCnt), 65535);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("cnt saturated", int'(CycleCnt), 65535);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
